// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM duty sequencer: FSM state codes and the minimum legal period.
package pwm_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    // Shorter periods cannot produce both a high and a low phase.
    localparam int unsigned PERIOD_MIN = 2;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running period counter: counts 0..period-1 while enabled, held at 0 while cleared,
// and flags the last cycle of each period.
module pwm_period_counter #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] period,
    output logic [W-1:0] cnt,
    output logic         period_end
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         last_cycle;

    // >= rather than == keeps the counter from running away if period ever shrinks under it.
    assign last_cycle = (cnt_q >= (period - W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last_cycle ? '0 : (cnt_q + W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt        = cnt_q;
    assign period_end = en && last_cycle;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// PWM sequencer with double-buffered period/duty updates applied at period boundaries.
// Optional soft-start duty ramp is enabled by defining PWM_SOFT_START_EN.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned W          = 7,
    parameter int unsigned PERIOD_DEF = 100,
    parameter int unsigned DUTY_DEF   = 20,
    parameter int unsigned RAMP_STEP  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_duty,
    output logic         Fsw,
    output logic         period_end,
    output logic         busy
);

    logic [1:0]   state_q, state_d;
    logic [W-1:0] per_act_q, per_act_d;
    logic [W-1:0] duty_tgt_q, duty_tgt_d;
    logic [W-1:0] shadow_per_q, shadow_per_d;
    logic [W-1:0] shadow_duty_q, shadow_duty_d;
    logic         pending_q, pending_d;
    logic         fsw_q, fsw_d;

    logic [W-1:0] cnt;
    logic [W-1:0] duty_eff;
    logic [W-1:0] per_clamped;
    logic         running;
    logic         xfer;
    logic         apply;

    assign running     = (state_q != ST_IDLE);
    assign xfer        = cfg_valid && !pending_q;
    // Idle: apply immediately; running: only on the boundary so the current period is never cut.
    assign apply       = pending_q && ((state_q == ST_IDLE) || period_end);
    assign per_clamped = (cfg_period < W'(PERIOD_MIN)) ? W'(PERIOD_MIN) : cfg_period;

    pwm_period_counter #(
        .W (W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clr        (state_q == ST_IDLE),
        .en         (running),
        .period     (per_act_q),
        .cnt        (cnt),
        .period_end (period_end)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_RUN;
            ST_RUN:      if (!start) state_d = ST_STOPPING;
            ST_STOPPING: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (period_end) begin
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shadow_per_d  = shadow_per_q;
        shadow_duty_d = shadow_duty_q;
        pending_d     = pending_q;
        per_act_d     = per_act_q;
        duty_tgt_d    = duty_tgt_q;
        if (xfer) begin
            shadow_per_d  = per_clamped;
            shadow_duty_d = cfg_duty;
            pending_d     = 1'b1;
        end
        if (apply) begin
            per_act_d  = shadow_per_q;
            duty_tgt_d = shadow_duty_q;
            pending_d  = 1'b0;
        end
    end

`ifdef PWM_SOFT_START_EN
    logic [W-1:0] duty_act_q, duty_act_d;
    logic [W-1:0] ramp_tgt;
    logic [W:0]   ramp_sum;

    assign ramp_tgt = apply ? shadow_duty_q : duty_tgt_q;
    assign ramp_sum = {1'b0, duty_act_q} + (W+1)'(RAMP_STEP);

    always_comb begin
        duty_act_d = duty_act_q;
        if ((state_q == ST_IDLE) && start) begin
            duty_act_d = '0;
        end else if (period_end) begin
            // A lower target takes effect at once; a higher one is approached in steps.
            if (ramp_tgt <= duty_act_q) begin
                duty_act_d = ramp_tgt;
            end else if (ramp_sum >= {1'b0, ramp_tgt}) begin
                duty_act_d = ramp_tgt;
            end else begin
                duty_act_d = ramp_sum[W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_act_q <= W'(DUTY_DEF);
        end else begin
            duty_act_q <= duty_act_d;
        end
    end

    assign duty_eff = duty_act_q;
`else
    logic unused_ramp_step;

    assign unused_ramp_step = ^RAMP_STEP;
    assign duty_eff         = duty_tgt_q;
`endif

    assign fsw_d = running && (cnt < duty_eff);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            per_act_q     <= W'(PERIOD_DEF);
            duty_tgt_q    <= W'(DUTY_DEF);
            shadow_per_q  <= W'(PERIOD_DEF);
            shadow_duty_q <= W'(DUTY_DEF);
            pending_q     <= 1'b0;
            fsw_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_act_q     <= per_act_d;
            duty_tgt_q    <= duty_tgt_d;
            shadow_per_q  <= shadow_per_d;
            shadow_duty_q <= shadow_duty_d;
            pending_q     <= pending_d;
            fsw_q         <= fsw_d;
        end
    end

    assign cfg_ready = !pending_q;
    assign Fsw       = fsw_q;
    assign busy      = running;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: table-driven period/duty vectors plus
// hand-written sequences for mid-period updates, graceful stop, reset and soft start.
module tb_pwm_duty_sequencer;

    localparam int W = 7;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_period = '0;
    logic [W-1:0] cfg_duty = '0;
    logic         cfg_ready;
    logic         Fsw;
    logic         period_end;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int period;
        int duty;
        int exp_per;
        int exp_high;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    pwm_duty_sequencer #(
        .W          (W),
        .PERIOD_DEF (100),
        .DUTY_DEF   (20),
        .RAMP_STEP  (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .Fsw        (Fsw),
        .period_end (period_end),
        .busy       (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting, expected event within bound", name);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Returns the number of negedges until period_end is seen high.
    task automatic wait_pe(input string name, output int steps);
        steps = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (period_end === 1'b1) begin
                steps = k;
                break;
            end
        end
        if (steps == 0) timeout_fail(name);
    endtask

    task automatic wait_idle(input string name);
        int found;
        found = 0;
        for (int k = 0; k <= 300; k++) begin
            if (busy === 1'b0) begin
                found = 1;
                break;
            end
            step();
        end
        if (found == 0) timeout_fail(name);
    endtask

    // Skips to the next boundary, then measures the following period's length and high time.
    // Fsw lags cnt by one cycle, so the high-time window is shifted by one.
    task automatic measure(input string name, output int per, output int high);
        int dummy;
        per  = 0;
        high = 0;
        wait_pe(name, dummy);
        for (int k = 1; k <= 300; k++) begin
            step();
            if (k >= 2 && (per == 0 || k <= per + 1) && Fsw === 1'b1) high++;
            if (per == 0 && period_end === 1'b1) per = k;
            if (per != 0 && k == per + 1) break;
        end
        if (per == 0) timeout_fail(name);
    endtask

    task automatic offer_idle(input int p, input int d);
        for (int k = 0; k < 50; k++) begin
            if (cfg_ready === 1'b1) break;
            step();
        end
        cfg_valid  = 1'b1;
        cfg_period = W'(p);
        cfg_duty   = W'(d);
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int steps;
        int per;
        int high;
        int cnt_hi;
        int cnt_pe;

        vecs[0] = '{period: 100, duty: 20,  exp_per: 100, exp_high: 20};
        vecs[1] = '{period: 50,  duty: 25,  exp_per: 50,  exp_high: 25};
        vecs[2] = '{period: 100, duty: 0,   exp_per: 100, exp_high: 0};
        vecs[3] = '{period: 100, duty: 120, exp_per: 100, exp_high: 100};
        vecs[4] = '{period: 1,   duty: 1,   exp_per: 2,   exp_high: 1};
        vecs[5] = '{period: 0,   duty: 5,   exp_per: 2,   exp_high: 2};
        vecs[6] = '{period: 10,  duty: 3,   exp_per: 10,  exp_high: 3};
        vecs[7] = '{period: 127, duty: 64,  exp_per: 127, exp_high: 64};

        // Reset state
        step();
        step();
        check("reset_fsw",        int'(Fsw), 0);
        check("reset_busy",       int'(busy), 0);
        check("reset_period_end", int'(period_end), 0);
        check("reset_cfg_ready",  int'(cfg_ready), 1);
        reset = 1'b1;
        step();

`ifdef PWM_SOFT_START_EN
        begin : soft_start
            int highs [6];
            int exp_h [6];
            exp_h = '{0, 5, 10, 15, 20, 20};
            for (int j = 0; j < 6; j++) highs[j] = 0;
            start = 1'b1;
            for (int i = 1; i <= 601; i++) begin
                step();
                if (i >= 2 && Fsw === 1'b1) highs[(i - 2) / 100]++;
            end
            for (int j = 0; j < 6; j++) check($sformatf("soft_high_p%0d", j), highs[j], exp_h[j]);
            start = 1'b0;
            wait_idle("soft_stop");
        end
`else
        // Defaults: first Fsw high two cycles after start is driven, period_end every 100
        start = 1'b1;
        step();
        check("start_busy",   int'(busy), 1);
        check("start_fsw_lo", int'(Fsw), 0);
        step();
        check("start_fsw_hi", int'(Fsw), 1);
        wait_pe("first_pe", steps);
        check("first_pe_steps", steps, 98);
        wait_pe("second_pe", steps);
        check("pe_interval", steps, 100);

        // Graceful stop at cnt=10
        for (int i = 0; i < 11; i++) step();
        start = 1'b0;
        wait_pe("stop_pe", steps);
        check("stop_pe_steps", steps, 89);
        check("stop_busy_at_pe", int'(busy), 1);
        step();
        check("stop_busy_after", int'(busy), 0);
        check("stop_fsw_after", int'(Fsw), 0);
        cnt_hi = 0;
        cnt_pe = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (Fsw === 1'b1) cnt_hi++;
            if (period_end === 1'b1) cnt_pe++;
        end
        check("idle_fsw_highs", cnt_hi, 0);
        check("idle_period_ends", cnt_pe, 0);

        // Mid-period update at cnt=30, plus a retried offer held while not ready
        start = 1'b1;
        step();
        wait_pe("mid_sync", steps);
        for (int i = 0; i < 31; i++) step();
        check("mid_ready_before", int'(cfg_ready), 1);
        cfg_valid  = 1'b1;
        cfg_period = W'(50);
        cfg_duty   = W'(25);
        step();
        check("mid_ready_low", int'(cfg_ready), 0);
        cfg_period = W'(40);
        cfg_duty   = W'(10);
        wait_pe("mid_cur_pe", steps);
        check("mid_cur_period_steps", steps, 68);
        check("mid_ready_at_pe", int'(cfg_ready), 0);
        step();
        check("mid_ready_after_pe", int'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        check("retry_taken", int'(cfg_ready), 0);
        wait_pe("mid_new_pe", steps);
        check("mid_new_period_steps", steps, 48);
        measure("retry_meas", per, high);
        check("retry_period", per, 40);
        check("retry_high", high, 10);
        start = 1'b0;
        wait_idle("mid_stop");

        // Table of period/duty vectors applied from IDLE
        for (int i = 0; i < 8; i++) begin
            offer_idle(vecs[i].period, vecs[i].duty);
            start = 1'b1;
            measure($sformatf("vec%0d", i), per, high);
            check($sformatf("vec%0d_period", i), per, vecs[i].exp_per);
            check($sformatf("vec%0d_high", i), high, vecs[i].exp_high);
            start = 1'b0;
            wait_idle($sformatf("vec%0d_stop", i));
        end

        // Asynchronous reset at cnt=57 while running 127/64
        start = 1'b1;
        for (int i = 0; i < 58; i++) step();
        check("prereset_fsw", int'(Fsw), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_fsw",        int'(Fsw), 0);
        check("async_busy",       int'(busy), 0);
        check("async_period_end", int'(period_end), 0);
        check("async_cfg_ready",  int'(cfg_ready), 1);
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        start = 1'b1;
        step();
        step();
        check("restart_fsw_hi", int'(Fsw), 1);
        wait_pe("restart_first_pe", steps);
        check("restart_first_pe_steps", steps, 98);
        measure("restart_meas", per, high);
        check("restart_period", per, 100);
        check("restart_high", high, 20);
        start = 1'b0;
        wait_idle("final_stop");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
